// File: rtl/gate_test_sequencer_pkg.sv
// rtl/gate_test_sequencer_pkg.sv - shared state encoding, expected vectors and gate_in bit indices
package gate_test_sequencer_pkg;

  // Sequencer states; encodings are fixed so lab captures decode consistently.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Expected gate_in for each {a,b}: {and, or, not a, xor, nand, nor}.
  localparam logic [5:0] EXP_00 = 6'h0B;
  localparam logic [5:0] EXP_01 = 6'h1E;
  localparam logic [5:0] EXP_10 = 6'h16;
  localparam logic [5:0] EXP_11 = 6'h30;

  // Bit positions of each gate output inside gate_in.
  localparam int BIT_C = 5;  // and
  localparam int BIT_D = 4;  // or
  localparam int BIT_E = 3;  // not a
  localparam int BIT_F = 2;  // xor
  localparam int BIT_G = 1;  // nand
  localparam int BIT_H = 0;  // nor

endpackage

// File: rtl/gate_test_sequencer_ref_model.sv
// rtl/gate_test_sequencer_ref_model.sv - combinational expected-vector lookup for one {a,b} pair
module gate_ref_model
  import gate_test_sequencer_pkg::*;
(
  input  logic       i_a,
  input  logic       i_b,
  output logic [5:0] o_exp
);

  // Table lookup of the golden gate outputs for the applied stimulus.
  always_comb begin
    o_exp = EXP_00;
    case ({i_a, i_b})
      2'b00:   o_exp = EXP_00;
      2'b01:   o_exp = EXP_01;
      2'b10:   o_exp = EXP_10;
      default: o_exp = EXP_11;
    endcase
  end

endmodule

// File: rtl/gate_test_sequencer.sv
// rtl/gate_test_sequencer.sv - sweeps a/b over all combinations and checks the six gate outputs
module gate_test_sequencer
  import gate_test_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       gate_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic             ok,
  output logic [3:0]       fail_mask,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       PASS_LAST   = 4'(NUM_PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_combo;
  logic [3:0]       r_pass_cnt;
  logic [3:0]       r_settle_cnt;
  logic             r_a;
  logic             r_b;
  logic             r_busy;
  logic             r_ok;
  logic [3:0]       r_fail_mask;
  logic [ERR_W-1:0] r_err_count;

  logic [5:0]       w_exp;
  logic             w_mismatch;
  logic             w_settle_last;
  logic             w_last_check;

  // Expected vector follows the registered stimulus, so it is stable through SETTLE and CHECK.
  gate_ref_model u_ref (
    .i_a   (r_a),
    .i_b   (r_b),
    .o_exp (w_exp)
  );

  assign w_mismatch    = (gate_in != w_exp);
  assign w_settle_last = (r_settle_cnt == SETTLE_LAST);
  assign w_last_check  = (r_combo == 2'd3) && (r_pass_cnt == PASS_LAST);

  // State register; reset aborts any run without producing a done pulse.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode; start only matters while idle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_SETTLE;
      ST_SETTLE: if (w_settle_last) w_state_nxt = ST_CHECK;
      ST_CHECK:  w_state_nxt = w_last_check ? ST_DONE : ST_SETTLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Stimulus, counters and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_combo      <= 2'd0;
      r_pass_cnt   <= 4'd0;
      r_settle_cnt <= 4'd0;
      r_a          <= 1'b0;
      r_b          <= 1'b0;
      r_busy       <= 1'b0;
      r_ok         <= 1'b0;
      r_fail_mask  <= 4'd0;
      r_err_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_combo      <= 2'd0;
            r_pass_cnt   <= 4'd0;
            r_settle_cnt <= 4'd0;
            r_a          <= 1'b0;
            r_b          <= 1'b0;
            r_busy       <= 1'b1;
            r_ok         <= 1'b0;
            r_fail_mask  <= 4'd0;
            r_err_count  <= '0;
          end
        end
        ST_SETTLE: begin
          r_settle_cnt <= r_settle_cnt + 4'd1;
        end
        ST_CHECK: begin
          if (w_mismatch) begin
            r_fail_mask[r_combo] <= 1'b1;
            if (r_err_count != ERR_MAX) r_err_count <= r_err_count + 1'b1;
          end
          if (!w_last_check) begin
            // Stimulus only moves here, on the edge that re-enters SETTLE.
            r_combo      <= r_combo + 2'd1;
            {r_a, r_b}   <= r_combo + 2'd1;
            r_settle_cnt <= 4'd0;
            if (r_combo == 2'd3) r_pass_cnt <= r_pass_cnt + 4'd1;
          end
        end
        default: begin
          r_ok   <= (r_fail_mask == 4'd0);
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign a_out     = r_a;
  assign b_out     = r_b;
  assign busy      = r_busy;
  assign done      = (r_state == ST_DONE);
  assign ok        = r_ok;
  assign fail_mask = r_fail_mask;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// tb/tb_gate_test_sequencer.sv - self-checking bench for gate_test_sequencer
module tb_gate_test_sequencer;

  localparam int S  = 2;
  localparam int PA = 1;
  localparam int PB = 3;

  logic clk = 1'b0;
  logic rst;
  logic start;

  logic       a_a, b_a, busy_a, done_a, ok_a;
  logic [3:0] fm_a, ec_a;
  logic [5:0] gi_a;
  logic       a_b, b_b, busy_b, done_b, ok_b;
  logic [3:0] fm_b, ec_b;
  logic [5:0] gi_b;
  logic       a_c, b_c, busy_c, done_c, ok_c;
  logic [3:0] fm_c;
  logic [2:0] ec_c;
  logic [5:0] gi_c;

  logic [5:0] and_mask;
  logic [5:0] flt [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [5:0] good(input logic a, input logic b);
    return {a & b, a | b, ~a, a ^ b, ~(a & b), ~(a | b)};
  endfunction

  always_comb gi_a = (good(a_a, b_a) & and_mask) ^ flt[{a_a, b_a}];
  always_comb gi_b = (good(a_b, b_b) & and_mask) ^ flt[{a_b, b_b}];
  always_comb gi_c = (good(a_c, b_c) & and_mask) ^ flt[{a_c, b_c}];

  gate_test_sequencer #(.SETTLE_CYCLES(S), .NUM_PASSES(PA), .ERR_W(4)) dut_a (
    .clk(clk), .rst(rst), .start(start), .gate_in(gi_a), .a_out(a_a), .b_out(b_a),
    .busy(busy_a), .done(done_a), .ok(ok_a), .fail_mask(fm_a), .err_count(ec_a));
  gate_test_sequencer #(.SETTLE_CYCLES(S), .NUM_PASSES(PB), .ERR_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start), .gate_in(gi_b), .a_out(a_b), .b_out(b_b),
    .busy(busy_b), .done(done_b), .ok(ok_b), .fail_mask(fm_b), .err_count(ec_b));
  gate_test_sequencer #(.SETTLE_CYCLES(S), .NUM_PASSES(PB), .ERR_W(3)) dut_c (
    .clk(clk), .rst(rst), .start(start), .gate_in(gi_c), .a_out(a_c), .b_out(b_c),
    .busy(busy_c), .done(done_c), .ok(ok_c), .fail_mask(fm_c), .err_count(ec_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_faults(input logic [5:0] am, input logic [5:0] f0, input logic [5:0] f1,
                            input logic [5:0] f2, input logic [5:0] f3);
    and_mask = am;
    flt[0] = f0; flt[1] = f1; flt[2] = f2; flt[3] = f3;
  endtask

  task automatic check_results(input string tag);
    logic [3:0] fm;
    int nbad, ea, eb, ec;
    fm = 4'd0;
    nbad = 0;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] kk;
      kk = 2'(k);
      if (((good(kk[1], kk[0]) & and_mask) ^ flt[k]) != good(kk[1], kk[0])) begin
        fm[k] = 1'b1;
        nbad++;
      end
    end
    ea = (PA * nbad > 15) ? 15 : PA * nbad;
    eb = (PB * nbad > 15) ? 15 : PB * nbad;
    ec = (PB * nbad > 7) ? 7 : PB * nbad;
    check({tag, "_fm_a"}, 32'(fm_a), 32'(fm));
    check({tag, "_ec_a"}, 32'(ec_a), 32'(ea));
    check({tag, "_ok_a"}, 32'(ok_a), 32'(fm == 4'd0));
    check({tag, "_fm_b"}, 32'(fm_b), 32'(fm));
    check({tag, "_ec_b"}, 32'(ec_b), 32'(eb));
    check({tag, "_fm_c"}, 32'(fm_c), 32'(fm));
    check({tag, "_ec_c"}, 32'(ec_c), 32'(ec));
    check({tag, "_ok_c"}, 32'(ok_c), 32'(fm == 4'd0));
  endtask

  // One run; restart_cyc > 0 pulses start again in that cycle.
  task automatic run(input string tag, input int restart_cyc);
    int dn_a, dn_b, dn_c, dc_a, dc_b, dc_c;
    logic [1:0] cmb;
    dn_a = 0; dn_b = 0; dn_c = 0; dc_a = 0; dc_b = 0; dc_c = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      if (n == 1) begin
        check({tag, "_ok_cleared"}, 32'(ok_a), 32'd0);
        check({tag, "_fm_cleared"}, 32'(fm_a), 32'd0);
      end
      if (done_a) begin dn_a++; dc_a = n; end
      if (done_b) begin dn_b++; dc_b = n; end
      if (done_c) begin dn_c++; dc_c = n; end
      if (n <= 4 * PA * (S + 1)) begin
        cmb = 2'(((n - 1) / (S + 1)) % 4);
        check($sformatf("%s_ab_c%0d", tag, n), 32'({a_a, b_a}), 32'(cmb));
      end
      check($sformatf("%s_busy_c%0d", tag, n), 32'(busy_a), 32'(n <= 4 * PA * (S + 1) + 1));
      start = (n == restart_cyc);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_ndone_a"}, 32'(dn_a), 32'd1);
    check({tag, "_cyc_a"}, 32'(dc_a), 32'(4 * PA * (S + 1) + 1));
    check({tag, "_ndone_b"}, 32'(dn_b), 32'd1);
    check({tag, "_cyc_b"}, 32'(dc_b), 32'(4 * PB * (S + 1) + 1));
    check({tag, "_ndone_c"}, 32'(dn_c), 32'd1);
    check({tag, "_cyc_c"}, 32'(dc_c), 32'(4 * PB * (S + 1) + 1));
    check_results(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a"}, 32'({a_a, b_a, busy_a, done_a, ok_a, fm_a, ec_a}), 32'd0);
    check({tag, "_b"}, 32'({a_b, b_b, busy_b, done_b, ok_b, fm_b, ec_b}), 32'd0);
    check({tag, "_c"}, 32'({a_c, b_c, busy_c, done_c, ok_c, fm_c, ec_c}), 32'd0);
  endtask

  initial begin
    int dn;
    rst = 1'b1;
    start = 1'b0;
    set_faults(6'h3F, 6'h00, 6'h00, 6'h00, 6'h00);
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    run("clean", 0);
    set_faults(6'h1F, 6'h00, 6'h00, 6'h00, 6'h00);
    run("stuck5", 0);
    set_faults(6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F);
    run("invert", 0);
    set_faults(6'h3F, 6'h00, 6'h00, 6'h00, 6'h00);
    run("restart", 5);

    // Abort an inverted run in cycle 6, then confirm a clean run afterwards.
    set_faults(6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_fm", 32'(fm_a), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("abort");
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      dn += int'(done_a) + int'(done_b) + int'(done_c);
    end
    check("abort_no_done", 32'(dn), 32'd0);
    set_faults(6'h3F, 6'h00, 6'h00, 6'h00, 6'h00);
    run("after_abort", 0);

    for (int t = 0; t < 4; t++) begin
      logic [5:0] am;
      logic [5:0] f [4];
      am = ($urandom_range(0, 1) != 0) ? 6'h3F : 6'($urandom_range(0, 63));
      for (int k = 0; k < 4; k++)
        f[k] = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(1, 63)) : 6'h00;
      set_faults(am, f[0], f[1], f[2], f[3]);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run($sformatf("rand%0d", t), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
